// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invchain_bist.sv
// LFSR-driven BIST for an inverter-chain test structure; INVCHAIN_BIST_FIRST_FAIL_EN adds FAIL_IDX capture.
// DONE follows the accepting START edge by 1 + NVEC*(SETTLE_CYC+2) cycles; no backpressure, START ignored while BUSY.
module gf180mcu_fd_sc_mcu7t5v0__invchain_bist #(
    parameter int CHAIN_LEN  = 1,
    parameter int SETTLE_CYC = 4,
    parameter int NVEC       = 256,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ZN_RET,
    output logic             I_DRV,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [15:0]      VEC_CNT
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
    ,
    output logic [15:0]      FAIL_IDX
`endif
);

    localparam int              SW        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic            INV_PAR   = ((CHAIN_LEN % 2) != 0);
    localparam logic [15:0]     LAST_VEC  = 16'(NVEC - 1);
    localparam logic [SW-1:0]   SETTLE_LD = SW'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 3) begin : g_bad_settle
        $error("SETTLE_CYC must be at least 3 to cover the 2-flop synchronizer");
    end
    if (NVEC < 1 || NVEC > 65535) begin : g_bad_nvec
        $error("NVEC must be in 1..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRIVE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       lfsr, lfsr_nxt;
    logic [SW-1:0]    settle, settle_nxt;
    logic             idrv_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [15:0]      vec_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic             zs_meta, zs;
    logic             lfsr_fb, mismatch;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
    logic [15:0]      fidx_nxt;
`endif

    // x^8+x^6+x^5+x^4+1, shifting toward bit 0
    assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4];
    assign mismatch = (zs != (I_DRV ^ INV_PAR));

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            zs_meta <= 1'b0;
            zs      <= 1'b0;
        end else begin
            zs_meta <= ZN_RET;
            zs      <= zs_meta;
        end
    end

    always_comb begin
        state_nxt  = state;
        lfsr_nxt   = lfsr;
        settle_nxt = settle;
        idrv_nxt   = I_DRV;
        err_nxt    = ERR_CNT;
        vec_nxt    = VEC_CNT;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
        fidx_nxt   = FAIL_IDX;
`endif
        case (state)
            ST_IDLE: begin
                if (START) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                lfsr_nxt  = 8'h01;
                err_nxt   = '0;
                vec_nxt   = '0;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
                fidx_nxt  = '0;
`endif
                state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                idrv_nxt   = lfsr[0];
                lfsr_nxt   = {lfsr_fb, lfsr[7:1]};
                settle_nxt = SETTLE_LD;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (settle == '0) state_nxt = ST_SAMPLE;
                else              settle_nxt = settle - SW'(1);
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (ERR_CNT != '1) err_nxt = ERR_CNT + ERR_W'(1);
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
                    if (ERR_CNT == '0) fidx_nxt = VEC_CNT;
`endif
                end
                vec_nxt   = VEC_CNT + 16'd1;
                state_nxt = (VEC_CNT == LAST_VEC) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                if (START) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status flags are registered from next-state so they align with the state register.
    assign busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_DRIVE) ||
                      (state_nxt == ST_WAIT) || (state_nxt == ST_SAMPLE);
    assign done_nxt = (state_nxt == ST_DONE);
    assign pass_nxt = done_nxt && (err_nxt == '0);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            lfsr     <= 8'h01;
            settle   <= '0;
            I_DRV    <= 1'b0;
            ERR_CNT  <= '0;
            VEC_CNT  <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
            FAIL_IDX <= '0;
`endif
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            settle   <= settle_nxt;
            I_DRV    <= idrv_nxt;
            ERR_CNT  <= err_nxt;
            VEC_CNT  <= vec_nxt;
            BUSY     <= busy_nxt;
            DONE     <= done_nxt;
            PASS     <= pass_nxt;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
            FAIL_IDX <= fidx_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__invchain_bist.sv
// Bench for the inverter-chain BIST: three instances (default, CHAIN_LEN=2, SETTLE_CYC=3) with behavioural chain models.
// Latency and result of each run are checked against a table of expected records held in a scoreboard queue.
module tb_gf180mcu_fd_sc_mcu7t5v0__invchain_bist;

    localparam int LIMIT = 4000;

    typedef struct {
        string       name;
        logic [1:0]  sel;       // 0: default dut, 1: CHAIN_LEN=2, 2: SETTLE_CYC=3
        int          mode;      // dut0: 0 ideal / 1 stuck-at-0; dut3: delay stages
        int          exp_lat;
        logic        exp_pass;
        logic [7:0]  exp_err;
        logic        err_any;   // only require a nonzero error count
        logic [15:0] exp_vec;
        logic        chk_fidx;
        logic [15:0] exp_fidx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rn  = 1'b0;
    logic [2:0]  start_v = 3'b000;
    logic        mode0 = 1'b0;
    logic        long3 = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [3:0]  dly = 4'h0;

    logic        zn0, zn2, zn3;
    logic        idrv0, idrv2, idrv3;
    logic        busy0, busy2, busy3, done0, done2, done3, pass0, pass2, pass3;
    logic [7:0]  err0, err2, err3;
    logic [15:0] vec0, vec2, vec3;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
    logic [15:0] fidx0, fidx2, fidx3, cur_fidx;
`endif
    logic        cur_busy, cur_done, cur_pass;
    logic [7:0]  cur_err;
    logic [15:0] cur_vec;

    int checks = 0;
    int errors = 0;
    vec_t tbl[5];
    vec_t sb[$];

    always #5 clk = ~clk;

    // Chain models: ideal/stuck inverter, plain inverter, and an inverter behind a negedge-clocked delay line.
    assign zn0 = mode0 ? 1'b0 : ~idrv0;
    assign zn2 = ~idrv2;
    assign zn3 = long3 ? ~dly[3] : ~dly[1];
    always @(negedge clk) dly <= {dly[2:0], idrv3};

    gf180mcu_fd_sc_mcu7t5v0__invchain_bist dut0 (
        .CLK(clk), .RN(rn), .START(start_v[0]), .ZN_RET(zn0), .I_DRV(idrv0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0), .VEC_CNT(vec0)
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
        , .FAIL_IDX(fidx0)
`endif
    );

    gf180mcu_fd_sc_mcu7t5v0__invchain_bist #(.CHAIN_LEN(2)) dut2 (
        .CLK(clk), .RN(rn), .START(start_v[1]), .ZN_RET(zn2), .I_DRV(idrv2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2), .VEC_CNT(vec2)
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
        , .FAIL_IDX(fidx2)
`endif
    );

    gf180mcu_fd_sc_mcu7t5v0__invchain_bist #(.SETTLE_CYC(3)) dut3 (
        .CLK(clk), .RN(rn), .START(start_v[2]), .ZN_RET(zn3), .I_DRV(idrv3),
        .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3), .VEC_CNT(vec3)
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
        , .FAIL_IDX(fidx3)
`endif
    );

    always_comb begin
        cur_busy = busy0; cur_done = done0; cur_pass = pass0; cur_err = err0; cur_vec = vec0;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
        cur_fidx = fidx0;
`endif
        case (sel)
            2'd1: begin
                cur_busy = busy2; cur_done = done2; cur_pass = pass2; cur_err = err2; cur_vec = vec2;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
                cur_fidx = fidx2;
`endif
            end
            2'd2: begin
                cur_busy = busy3; cur_done = done3; cur_pass = pass3; cur_err = err3; cur_vec = vec3;
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
                cur_fidx = fidx3;
`endif
            end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Starts one run on the selected instance; expectation is queued at START, checked at DONE.
    task automatic run_rec(input vec_t r, input bit hold);
        int   lat;
        logic prev_busy;
        vec_t e;
        sel = r.sel;
        if (r.sel == 2'd0) mode0 = r.mode[0];
        if (r.sel == 2'd2) long3 = (r.mode == 4);
        @(negedge clk);
        start_v[r.sel] = 1'b1;
        sb.push_back(r);
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_v[r.sel] = 1'b0;
        lat = 0;
        prev_busy = 1'b0;
        while (!cur_done && lat < LIMIT) begin
            prev_busy = cur_busy;
            @(negedge clk);
            lat++;
            if (lat == 1) chk({r.name, "_busy_early"}, {31'd0, cur_busy}, 32'd1);
        end
        e = sb.pop_front();
        if (lat >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no DONE after %0d cycles required=DONE", e.name, lat);
        end else begin
            chk({e.name, "_latency"}, lat, e.exp_lat);
            chk({e.name, "_busy_before_done"}, {31'd0, prev_busy}, 32'd1);
            chk({e.name, "_busy_at_done"}, {31'd0, cur_busy}, 32'd0);
            chk({e.name, "_pass"}, {31'd0, cur_pass}, {31'd0, e.exp_pass});
            if (e.err_any) chk({e.name, "_err_nonzero"}, {31'd0, (cur_err != 8'd0)}, 32'd1);
            else           chk({e.name, "_err_cnt"}, {24'd0, cur_err}, {24'd0, e.exp_err});
            chk({e.name, "_vec_cnt"}, {16'd0, cur_vec}, {16'd0, e.exp_vec});
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
            if (e.chk_fidx) chk({e.name, "_fail_idx"}, {16'd0, cur_fidx}, {16'd0, e.exp_fidx});
`endif
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{"ideal",  2'd0, 0, 1537, 1'b1, 8'd0,   1'b0, 16'd256, 1'b1, 16'd0};
        tbl[1] = '{"stuck0", 2'd0, 1, 1537, 1'b0, 8'd127, 1'b0, 16'd256, 1'b1, 16'd1};
        tbl[2] = '{"chain2", 2'd1, 0, 1537, 1'b0, 8'd255, 1'b0, 16'd256, 1'b1, 16'd0};
        tbl[3] = '{"dly2",   2'd2, 2, 1281, 1'b1, 8'd0,   1'b0, 16'd256, 1'b1, 16'd0};
        tbl[4] = '{"dly4",   2'd2, 4, 1281, 1'b0, 8'd0,   1'b1, 16'd256, 1'b0, 16'd0};

        // Reset state
        #23;
        chk("rst_i_drv", {31'd0, idrv0}, 32'd0);
        chk("rst_busy",  {31'd0, busy0}, 32'd0);
        chk("rst_done",  {31'd0, done0}, 32'd0);
        chk("rst_pass",  {31'd0, pass0}, 32'd0);
        chk("rst_err",   {24'd0, err0},  32'd0);
        chk("rst_vec",   {16'd0, vec0},  32'd0);
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
        chk("rst_fidx",  {16'd0, fidx0}, 32'd0);
`endif
        @(negedge clk);
        rn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'd0, busy0}, 32'd0);

        for (int i = 0; i < 5; i++) run_rec(tbl[i], 1'b0);

        // START held high: ignored while busy, then restarts right after DONE
        run_rec(tbl[1], 1'b1);
        @(negedge clk);
        chk("held_reload_busy", {31'd0, busy0}, 32'd1);
        chk("held_reload_done", {31'd0, done0}, 32'd0);
        @(negedge clk);
        chk("held_cleared_err", {24'd0, err0}, 32'd0);
        chk("held_cleared_vec", {16'd0, vec0}, 32'd0);
        start_v[0] = 1'b0;
        n = 1;
        while (!done0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("held_run2_latency", n, 32'd1537);
        chk("held_run2_err", {24'd0, err0}, 32'd127);

        // Asynchronous reset mid-run
        mode0 = 1'b1;
        sel = 2'd0;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (699) @(negedge clk);
        chk("mid_busy", {31'd0, busy0}, 32'd1);
        chk("mid_err_nonzero", {31'd0, (err0 != 8'd0)}, 32'd1);
        #2 rn = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, busy0}, 32'd0);
        chk("arst_done",  {31'd0, done0}, 32'd0);
        chk("arst_i_drv", {31'd0, idrv0}, 32'd0);
        chk("arst_err",   {24'd0, err0},  32'd0);
        chk("arst_vec",   {16'd0, vec0},  32'd0);
`ifdef INVCHAIN_BIST_FIRST_FAIL_EN
        chk("arst_fidx",  {16'd0, fidx0}, 32'd0);
`endif
        @(negedge clk);
        rn = 1'b1;
        run_rec(tbl[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
